// File: rtl/sram_pkg.sv
// Shared constants and FSM encoding for the asynchronous-SRAM pin responder.
package sram_pkg;
  localparam int DATA_W       = 32;
  localparam int BYTE_W       = 8;
  localparam int NUM_BYTES    = DATA_W / BYTE_W;
  localparam int READ_LAT_MAX = 7;
  localparam int LAT_W        = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_DRIVE = 2'd2,
    WR_ACT   = 2'd3
  } state_t;
endpackage

// File: rtl/sram_resp_array.sv
// Word array behind the responder: synchronous registered read, per-byte write enable.
module sram_resp_array
  import sram_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                 clk50,
  input  logic [NUM_BYTES-1:0] we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [ADDR_W-1:0]    raddr,
  output logic [DATA_W-1:0]    rdata
);
  logic [NUM_BYTES-1:0][BYTE_W-1:0] mem [2**ADDR_W];

  // Contents deliberately have no reset: the array survives rst_n like a real chip.
  always_ff @(posedge clk50) begin
    for (int k = 0; k < NUM_BYTES; k++)
      if (we[k]) mem[waddr][k] <= wdata[k*BYTE_W +: BYTE_W];
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/sram_responder.sv
// Device-side responder for the 32-bit async-SRAM pin interface.
// Optional checker enabled by defining SRAM_RESP_PROTOCOL_CHECK_EN.
module sram_responder
  import sram_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 0
) (
  input  logic                 clk50,
  input  logic                 rst_n,
  input  logic                 ce_n_i,
  input  logic                 oe_n_i,
  input  logic                 we_n_i,
  input  logic [NUM_BYTES-1:0] be_n_i,
  input  logic [19:0]          addr_i,
  inout  wire  [DATA_W-1:0]    data_io,
  output logic                 drive_o,
  output logic                 proto_err_o
);
  logic rd, wr, commit;
  state_t state, state_nxt;
  logic [LAT_W-1:0] lat_cnt, lat_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [NUM_BYTES-1:0] be_q, drv;
  logic [DATA_W-1:0] wdata_q, data_q;
  logic unused_addr;

  assign rd = ~ce_n_i & ~oe_n_i & we_n_i;
  assign wr = ~ce_n_i & ~we_n_i;
  assign unused_addr = ^addr_i[19:ADDR_W];

  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_cnt;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (wr) state_nxt = WR_ACT;
        else if (rd) begin
          state_nxt = RD_WAIT;
          lat_nxt   = LAT_W'(READ_LAT);
        end
      end
      RD_WAIT: begin
        if (!rd) state_nxt = IDLE;
        else if (lat_cnt == '0) state_nxt = RD_DRIVE;
        else lat_nxt = lat_cnt - 1'b1;
      end
      RD_DRIVE: begin
        if (wr) state_nxt = WR_ACT;
        else if (!rd) state_nxt = IDLE;
      end
      WR_ACT: begin
        if (!wr) begin
          commit = 1'b1;
          if (rd) begin
            state_nxt = RD_WAIT;
            lat_nxt   = LAT_W'(READ_LAT);
          end else state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lat_cnt <= '0;
      addr_q  <= '0;
      be_q    <= '1;
      wdata_q <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_nxt;
      // Every WR cycle overwrites the latches; the last one before WE_n rises wins.
      if (wr) begin
        addr_q  <= addr_i[ADDR_W-1:0];
        be_q    <= be_n_i;
        wdata_q <= data_io;
      end
    end
  end

  // The read port re-registers every cycle, which gives RD_DRIVE its address-follow behaviour.
  sram_resp_array #(.ADDR_W(ADDR_W)) u_array (
    .clk50 (clk50),
    .we    (commit ? ~be_q : '0),
    .waddr (addr_q),
    .wdata (wdata_q),
    .raddr (addr_i[ADDR_W-1:0]),
    .rdata (data_q)
  );

  // Enables use live pins so OE_n/CE_n rising releases the bus in the same cycle.
  for (genvar k = 0; k < NUM_BYTES; k++) begin : g_lane
    assign drv[k] = (state == RD_DRIVE) & rd & ~be_n_i[k];
    assign data_io[k*BYTE_W +: BYTE_W] = drv[k] ? data_q[k*BYTE_W +: BYTE_W] : {BYTE_W{1'bz}};
  end
  assign drive_o = |drv;

`ifdef SRAM_RESP_PROTOCOL_CHECK_EN
  logic [19:0] chk_addr_q;
  logic viol;
  assign viol = (~ce_n_i & ~oe_n_i & ~we_n_i)
              | ((state == WR_ACT) & wr & ((addr_i != chk_addr_q) | (be_n_i != be_q)))
              | $isunknown({ce_n_i, oe_n_i, we_n_i});
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      proto_err_o <= 1'b0;
      chk_addr_q  <= '0;
    end else begin
      if (viol) proto_err_o <= 1'b1;
      if (wr) chk_addr_q <= addr_i;
    end
  end
`else
  assign proto_err_o = 1'b0;
`endif
endmodule
